// File: rtl/tluh_32_pkg.sv
// TL-UL 32-bit bus types shared by hosts and devices on this fabric.
package tluh_32_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_pkg.sv
// Helpers for the TL-UL host arbiter: round-robin pointer advance.
package tlul_host_arb_pkg;

    // Pointer moves past the winner; with host 0 on strict priority it is never a rr slot.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n,
                                            input bit skip0);
        int unsigned nxt;
        nxt = (idx + 1) % n;
        if (skip0 && nxt == 0) nxt = 1;
        return nxt;
    endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with optional empty pass-through; rst_ni is sampled on the clock edge.
module prim_fifo_sync #(
    parameter int unsigned Width = 16,
    parameter bit          Pass  = 1'b1,
    parameter int unsigned Depth = 4,
    localparam int unsigned DepthW = $clog2(Depth + 1),
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o
);
    logic [Width-1:0]  mem_q [Depth];
    logic [Width-1:0]  mem_d [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DepthW-1:0] cnt_q, cnt_d;
    logic              empty, full, pass_thru, do_push, do_pop;

    always_comb begin
        empty     = (cnt_q == '0);
        full      = (cnt_q == DepthW'(Depth));
        pass_thru = Pass && empty && wvalid_i && rready_i;
        do_push   = wvalid_i && !full && !pass_thru;
        do_pop    = rready_i && !empty;
        wready_o  = !full;
        rvalid_o  = !empty || (Pass && wvalid_i);
        rdata_o   = (Pass && empty) ? wdata_i : mem_q[rptr_q];
        depth_o   = cnt_q;
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) cnt_d = cnt_q + DepthW'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - DepthW'(1);
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tlul_arb_rr.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
module tlul_arb_rr #(
    parameter int N    = 2,
    parameter int IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);
    always_comb begin
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/tlul_host_arb.sv
// N-to-1 TL-UL host arbiter with in-order response routing.
// Define TLUL_HOST_ARB_PRIO0_EN to give host 0 strict priority over the round-robin hosts.
module tlul_host_arb
    import tluh_32_pkg::*;
    import tlul_host_arb_pkg::*;
#(
    parameter int NumHosts       = 2,
    parameter int MaxOutstanding = 4,
    parameter int IdxW           = (NumHosts > 1) ? $clog2(NumHosts) : 1,
    localparam int OccW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  tl_h2d_t         tl_h_i [NumHosts],
    output tl_d2h_t         tl_h_o [NumHosts],
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    output logic [OccW-1:0] outstanding_o,
    output logic            err_unexp_o
);
    localparam int EntryW = IdxW;
`ifdef TLUL_HOST_ARB_PRIO0_EN
    localparam bit SkipHost0 = 1'b1;
`else
    localparam bit SkipHost0 = 1'b0;
`endif

    logic [NumHosts-1:0] req, arb_req, arb_gnt;
    logic [IdxW-1:0]     arb_idx, gnt_idx;
    logic [EntryW-1:0]   head_idx;
    logic                gnt_valid, fwd, accept, pop;
    logic                fifo_wready, fifo_rvalid;
    logic                lock_q, lock_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d, rr_ptr_q, rr_ptr_d;

    always_comb begin
        req = '0;
        for (int i = 0; i < NumHosts; i++) req[i] = tl_h_i[i].a_valid;
        arb_req = req;
        if (SkipHost0) arb_req[0] = 1'b0;
    end

    tlul_arb_rr #(
        .N    (NumHosts),
        .IdxW (IdxW)
    ) u_rr (
        .req_i (arb_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // A held grant wins over both priority and round-robin so A fields stay stable.
    always_comb begin
        gnt_idx   = arb_idx;
        gnt_valid = |arb_gnt;
        if (SkipHost0 && req[0]) begin
            gnt_idx   = '0;
            gnt_valid = 1'b1;
        end
        if (lock_q) begin
            gnt_idx   = lock_idx_q;
            gnt_valid = 1'b1;
        end
    end

    assign fwd         = gnt_valid && req[gnt_idx] && fifo_wready && !rst_i;
    assign accept      = fwd && tl_d_i.a_ready;
    assign pop         = fifo_rvalid && tl_d_i.d_valid && tl_d_o.d_ready;
    assign err_unexp_o = tl_d_i.d_valid && !fifo_rvalid && !rst_i;

    always_comb begin
        tl_d_o         = tl_h_i[gnt_idx];
        tl_d_o.a_valid = fwd;
        tl_d_o.d_ready = fifo_rvalid ? tl_h_i[head_idx].d_ready : 1'b1;
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = '0;
            if (fifo_rvalid && head_idx == EntryW'(i)) tl_h_o[i] = tl_d_i;
            tl_h_o[i].a_ready = gnt_valid && (gnt_idx == IdxW'(i)) && tl_d_i.a_ready
                                && fifo_wready && !rst_i;
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = IdxW'(rr_next(32'(gnt_idx), NumHosts, SkipHost0));
        end else if (fwd) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    prim_fifo_sync #(
        .Width (EntryW),
        .Pass  (1'b0),
        .Depth (MaxOutstanding)
    ) u_route_fifo (
        .clk_i    (clk_i),
        .rst_ni   (!rst_i),
        .clr_i    (1'b0),
        .wvalid_i (accept),
        .wready_o (fifo_wready),
        .wdata_i  (gnt_idx),
        .rvalid_o (fifo_rvalid),
        .rready_i (pop),
        .rdata_o  (head_idx),
        .depth_o  (outstanding_o)
    );

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed bench for tlul_host_arb: per-cycle vector table plus lock, single-host and reset sequences.
module tb_tlul_host_arb;
    import tluh_32_pkg::*;

    localparam int NH = 3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    tl_h2d_t    tl_h_i [NH];
    tl_d2h_t    tl_h_o [NH];
    tl_h2d_t    tl_d_o;
    tl_d2h_t    tl_d_i;
    logic [2:0] outstanding_o;
    logic       err_unexp_o;

    int checks   = 0;
    int failures = 0;

    logic [NH-1:0] ardy_m, dvld_m;

    typedef struct packed {
        logic [2:0] hv;
        logic [2:0] hdr;
        logic       dar;
        logic       ddv;
        logic       e_dav;
        logic [1:0] e_src;
        logic [2:0] e_ardy;
        logic [2:0] e_dvld;
        logic       e_dr;
        logic       e_err;
        logic [2:0] e_occ;
    } vec_t;

    vec_t vt [23];

    tlul_host_arb #(
        .NumHosts       (NH),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tl_h_i        (tl_h_i),
        .tl_h_o        (tl_h_o),
        .tl_d_o        (tl_d_o),
        .tl_d_i        (tl_d_i),
        .outstanding_o (outstanding_o),
        .err_unexp_o   (err_unexp_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        ardy_m = '0;
        dvld_m = '0;
        for (int i = 0; i < NH; i++) begin
            ardy_m[i] = tl_h_o[i].a_ready;
            dvld_m[i] = tl_h_o[i].d_valid;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] hv, input logic [2:0] hdr, input logic dar,
                         input logic ddv);
        for (int i = 0; i < NH; i++) begin
            tl_h_i[i].a_valid = hv[i];
            tl_h_i[i].d_ready = hdr[i];
        end
        tl_d_i.a_ready = dar;
        tl_d_i.d_valid = ddv;
    endtask

    // Drive just after a rising edge; caller samples at the following falling edge.
    task automatic cyc(input logic [2:0] hv, input logic [2:0] hdr, input logic dar,
                       input logic ddv);
        @(posedge clk_i);
        #1;
        drive(hv, hdr, dar, ddv);
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < NH; i++) begin
            tl_h_i[i]           = '0;
            tl_h_i[i].a_opcode  = Get;
            tl_h_i[i].a_size    = 2'd2;
            tl_h_i[i].a_source  = 8'(i);
            tl_h_i[i].a_address = 32'h1000 * (i + 1);
            tl_h_i[i].a_mask    = 4'hF;
        end
        tl_d_i          = '0;
        tl_d_i.d_opcode = AccessAckData;
        rst_i = 1'b1;
        drive(3'b000, 3'b111, 1'b0, 1'b0);

        //        hv      hdr     dar   ddv   dav   src    ardy    dvld    dr    err   occ
        vt[0]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b0, 3'd0};
        vt[1]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 3'b000, 1'b1, 1'b0, 3'd1};
        vt[2]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd2, 3'b100, 3'b000, 1'b1, 1'b0, 3'd2};
        vt[3]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b0, 3'd3};
        vt[4]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd1, 3'b000, 3'b000, 1'b1, 1'b0, 3'd4};
        vt[5]  = '{3'b111, 3'b111, 1'b1, 1'b1, 1'b0, 2'd1, 3'b000, 3'b001, 1'b1, 1'b0, 3'd4};
        vt[6]  = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 3'b000, 1'b1, 1'b0, 3'd3};
        vt[7]  = '{3'b111, 3'b111, 1'b1, 1'b1, 1'b0, 2'd2, 3'b000, 3'b010, 1'b1, 1'b0, 3'd4};
        vt[8]  = '{3'b111, 3'b111, 1'b1, 1'b1, 1'b1, 2'd2, 3'b100, 3'b100, 1'b1, 1'b0, 3'd3};
        vt[9]  = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b001, 1'b1, 1'b0, 3'd3};
        vt[10] = '{3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b010, 1'b0, 1'b0, 3'd2};
        vt[11] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b010, 1'b1, 1'b0, 3'd2};
        vt[12] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b100, 1'b1, 1'b0, 3'd1};
        vt[13] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b1, 3'd0};
        vt[14] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 3'd0};
        vt[15] = '{3'b001, 3'b111, 1'b1, 1'b1, 1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b1, 3'd0};
        vt[16] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b001, 1'b1, 1'b0, 3'd1};
        vt[17] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 3'd0};
        vt[18] = '{3'b011, 3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 3'b000, 1'b1, 1'b0, 3'd0};
        vt[19] = '{3'b011, 3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b0, 3'd1};
        vt[20] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b010, 1'b1, 1'b0, 3'd2};
        vt[21] = '{3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b001, 1'b1, 1'b0, 3'd1};
        vt[22] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 3'd0};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst occ", 32'(outstanding_o), 32'd0);
        chk("rst err", 32'(err_unexp_o), 32'd0);
        chk("rst a_valid", 32'(tl_d_o.a_valid), 32'd0);
        chk("rst a_ready", 32'(ardy_m), 32'd0);
        chk("rst d_valid", 32'(dvld_m), 32'd0);

        // Round-robin, full stall, response routing, unexpected responses
        for (int k = 0; k < 23; k++) begin
            cyc(vt[k].hv, vt[k].hdr, vt[k].dar, vt[k].ddv);
            chk($sformatf("v%0d a_valid", k), 32'(tl_d_o.a_valid), 32'(vt[k].e_dav));
            if (vt[k].e_dav)
                chk($sformatf("v%0d a_source", k), 32'(tl_d_o.a_source), 32'(vt[k].e_src));
            chk($sformatf("v%0d a_ready", k), 32'(ardy_m), 32'(vt[k].e_ardy));
            chk($sformatf("v%0d d_valid", k), 32'(dvld_m), 32'(vt[k].e_dvld));
            chk($sformatf("v%0d d_ready", k), 32'(tl_d_o.d_ready), 32'(vt[k].e_dr));
            chk($sformatf("v%0d err", k), 32'(err_unexp_o), 32'(vt[k].e_err));
            chk($sformatf("v%0d occ", k), 32'(outstanding_o), 32'(vt[k].e_occ));
        end

        // Backpressure lock: rr pointer is at host 1, host 0 grabbed the grant first
        cyc(3'b001, 3'b111, 1'b0, 1'b0);
        chk("lock first src", 32'(tl_d_o.a_source), 32'd0);
        chk("lock first a_valid", 32'(tl_d_o.a_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(3'b011, 3'b111, 1'b0, 1'b0);
            chk($sformatf("lock%0d src", k), 32'(tl_d_o.a_source), 32'd0);
            chk($sformatf("lock%0d addr", k), tl_d_o.a_address, 32'h1000);
            chk($sformatf("lock%0d a_ready", k), 32'(ardy_m), 32'd0);
        end
        cyc(3'b011, 3'b111, 1'b1, 1'b0);
        chk("lock accept src", 32'(tl_d_o.a_source), 32'd0);
        chk("lock accept a_ready", 32'(ardy_m), 32'b001);
        cyc(3'b010, 3'b111, 1'b1, 1'b0);
        chk("lock next src", 32'(tl_d_o.a_source), 32'd1);
        chk("lock next a_ready", 32'(ardy_m), 32'b010);
        cyc(3'b000, 3'b111, 1'b1, 1'b1);
        chk("lock drain0", 32'(dvld_m), 32'b001);
        cyc(3'b000, 3'b111, 1'b1, 1'b1);
        chk("lock drain1", 32'(dvld_m), 32'b010);
        cyc(3'b000, 3'b111, 1'b1, 1'b0);
        chk("lock drained occ", 32'(outstanding_o), 32'd0);

        // Single host Get answered two cycles after accept
        tl_h_i[1].a_address = 32'h10;
        tl_d_i.d_data       = 32'hDEADBEEF;
        cyc(3'b010, 3'b111, 1'b1, 1'b0);
        chk("single a_valid", 32'(tl_d_o.a_valid), 32'd1);
        chk("single addr", tl_d_o.a_address, 32'h10);
        chk("single opcode", 32'(tl_d_o.a_opcode), 32'(Get));
        cyc(3'b000, 3'b111, 1'b1, 1'b0);
        chk("single occ wait", 32'(outstanding_o), 32'd1);
        chk("single d_valid wait", 32'(dvld_m), 32'd0);
        cyc(3'b000, 3'b111, 1'b1, 1'b1);
        chk("single d_valid", 32'(dvld_m), 32'b010);
        chk("single d_data", tl_h_o[1].d_data, 32'hDEADBEEF);
        chk("single d_opcode", 32'(tl_h_o[1].d_opcode), 32'(AccessAckData));
        chk("single other data", tl_h_o[0].d_data, 32'd0);
        chk("single occ resp", 32'(outstanding_o), 32'd1);
        cyc(3'b000, 3'b111, 1'b1, 1'b0);
        chk("single occ done", 32'(outstanding_o), 32'd0);
        tl_h_i[1].a_address = 32'h2000;

        // Reset mid-flight: rr pointer ends on host 2 before reset
        cyc(3'b111, 3'b111, 1'b1, 1'b0);
        chk("mid src0", 32'(tl_d_o.a_source), 32'd2);
        cyc(3'b111, 3'b111, 1'b1, 1'b0);
        chk("mid src1", 32'(tl_d_o.a_source), 32'd0);
        cyc(3'b111, 3'b111, 1'b1, 1'b0);
        chk("mid src2", 32'(tl_d_o.a_source), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        drive(3'b000, 3'b111, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("mid occ before rst", 32'(outstanding_o), 32'd3);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(3'b000, 3'b111, 1'b1, 1'b1);
        @(negedge clk_i);
        chk("post rst occ", 32'(outstanding_o), 32'd0);
        chk("post rst d_valid", 32'(dvld_m), 32'd0);
        chk("post rst err", 32'(err_unexp_o), 32'd1);
        chk("post rst a_valid", 32'(tl_d_o.a_valid), 32'd0);
        cyc(3'b110, 3'b111, 1'b1, 1'b0);
        chk("post rst ptr src", 32'(tl_d_o.a_source), 32'd1);
        chk("post rst ptr a_ready", 32'(ardy_m), 32'b010);
        cyc(3'b100, 3'b111, 1'b1, 1'b0);
        chk("post rst host2 src", 32'(tl_d_o.a_source), 32'd2);
        chk("post rst host2 a_ready", 32'(ardy_m), 32'b100);
        cyc(3'b000, 3'b111, 1'b1, 1'b1);
        chk("post rst route1", 32'(dvld_m), 32'b010);
        cyc(3'b000, 3'b111, 1'b1, 1'b1);
        chk("post rst route2", 32'(dvld_m), 32'b100);
        cyc(3'b000, 3'b111, 1'b1, 1'b0);
        chk("post rst occ end", 32'(outstanding_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
